// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch sequencer.
//   fe_state_t : sequencer state encoding
//   DEF_*      : default address / instruction / counter widths
package fetch_pkg;

  localparam int unsigned DEF_D  = 12;
  localparam int unsigned DEF_IW = 9;
  localparam int unsigned DEF_CW = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fe_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the benchmarking counters.
//   clk_i   : clock
//   reset_i : synchronous active-high reset (count -> 0)
//   clr_i   : synchronous clear, wins over inc_i
//   inc_i   : count up by one unless already all-ones
//   cnt_o   : current count
module sat_counter #(
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: owns the PC, fetches over a req/ack memory
// handshake, holds each word for decode with stall back-pressure, applies
// absolute / relative branches and stops at HALT_ADDR.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | after reset, waiting for start
// FETCH | imem_req high at pc, waiting for imem_ack
// ISSUE | instr_valid high, retires when stall is low
// HALT  | pc reached HALT_ADDR, done high, waiting for restart
//
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   start_i                 : (re)start at RESET_PC, honoured in IDLE/HALT
//   imem_addr_o/imem_req_o  : fetch address (= pc) and request
//   imem_ack_i/imem_data_i  : memory response
//   instr_o/instr_valid_o   : held instruction for decode
//   stall_i                 : back end not ready
//   abs_jump_i/rel_jump_i   : branch controls, target_i = address/offset
//   done_o                  : high in HALT
//   cycle_cnt_o/instr_cnt_o : saturating benchmarking counters
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int unsigned     D         = DEF_D,
  parameter int unsigned     IW        = DEF_IW,
  parameter int unsigned     CW        = DEF_CW,
  parameter logic [D-1:0]    RESET_PC  = '0,
  parameter logic [D-1:0]    HALT_ADDR = {D{1'b1}}
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  output logic [D-1:0]  imem_addr_o,
  output logic          imem_req_o,
  input  logic          imem_ack_i,
  input  logic [IW-1:0] imem_data_i,
  output logic [IW-1:0] instr_o,
  output logic          instr_valid_o,
  input  logic          stall_i,
  input  logic          abs_jump_i,
  input  logic          rel_jump_i,
  input  logic [D-1:0]  target_i,
  output logic          done_o,
  output logic [CW-1:0] cycle_cnt_o,
  output logic [CW-1:0] instr_cnt_o
);

  fe_state_t     state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [D-1:0]  pc_nxt;
  logic          start_ok;
  logic          retire;
  logic          running;

  assign start_ok = start_i && ((state_q == IDLE) || (state_q == HALT));
  assign retire   = (state_q == ISSUE) && !stall_i;
  assign running  = (state_q == FETCH) || (state_q == ISSUE);

  // Branch target; D-bit arithmetic wraps modulo 2^D by construction.
  always_comb begin
    if (abs_jump_i) begin
      pc_nxt = target_i;
    end else if (rel_jump_i) begin
      pc_nxt = pc_q + target_i;
    end else begin
      pc_nxt = pc_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE, HALT: begin
        if (start_i) begin
          pc_d    = RESET_PC;
          state_d = (RESET_PC == HALT_ADDR) ? HALT : FETCH;
        end
      end
      FETCH: begin
        if (imem_ack_i) begin
          instr_d = imem_data_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall_i) begin
          pc_d    = pc_nxt;
          state_d = (pc_nxt == HALT_ADDR) ? HALT : FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  sat_counter #(.CW(CW)) u_cycle_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (start_ok),
    .inc_i   (running),
    .cnt_o   (cycle_cnt_o)
  );

  sat_counter #(.CW(CW)) u_instr_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr_i   (start_ok),
    .inc_i   (retire),
    .cnt_o   (instr_cnt_o)
  );

  // Status outputs decode registered state only.
  assign imem_addr_o   = pc_q;
  assign imem_req_o    = (state_q == FETCH);
  assign instr_valid_o = (state_q == ISSUE);
  assign done_o        = (state_q == HALT);
  assign instr_o       = instr_q;

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
Parametrised instruction-fetch sequencer for the next-generation core. It owns the program counter and talks to a variable-latency instruction memory through a req/ack handshake. Each fetched word is held and issued to decode/execute with a back-pressure (stall) input. It also applies absolute and relative branches, detects the halt address (sticky done) and keeps saturating cycle and retired-instruction counters for benchmarking programs.

Parameters:
D, 12, program counter / instruction address width
IW, 9, instruction word width
CW, 16, width of cycle and instruction counters
RESET_PC, 0, address of first instruction after start
HALT_ADDR, {D{1'b1}}, PC value that terminates execution

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  begin (or restart) execution at RESET_PC; sampled in IDLE and HALT only
imem_addr  out  D  fetch address (= pc)
imem_req  out  1  fetch request, high throughout FETCH
imem_ack  in  1  memory returns imem_data this cycle; ignored outside FETCH
imem_data  in  IW  instruction word, valid when imem_ack
instr  out  IW  held instruction for decode
instr_valid  out  1  high in ISSUE; instr valid
stall  in  1  back end not ready; instruction not retired this cycle
abs_jump  in  1  retire with pc <= target
rel_jump  in  1  retire with pc <= pc + target (signed)
target  in  D  jump target / two's-complement offset
done  out  1  sticky, high in HALT
cycle_cnt  out  CW  cycles spent in FETCH+ISSUE since start, saturating
instr_cnt  out  CW  retired instructions since start, saturating

Behaviour:
- Reset (sync, any state, mid-fetch included): state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, done=0, cycle_cnt=0, instr_cnt=0. A pending memory ack after reset is ignored.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: outputs quiescent. start=1 -> pc=RESET_PC, counters cleared. Next state is HALT if RESET_PC==HALT_ADDR, else FETCH.
- FETCH: imem_req=1, imem_addr=pc. imem_ack=1 -> instr<=imem_data, next ISSUE. With no ack, remain in FETCH indefinitely; no timeout.
- A combinational (same-cycle) ack is legal, so the minimum is 2 cycles per instruction.
- ISSUE: instr_valid=1, instr held stable.
  - stall=1: remain in ISSUE; pc and instr unchanged; jump inputs ignored.
  - stall=0: retire. instr_cnt+1. Next pc:
    - abs_jump=1 -> target (abs_jump has priority over rel_jump);
    - else rel_jump=1 -> pc + target, computed modulo 2^D (wrap-around legal);
    - else pc+1, also modulo 2^D.
  - After retire: next state is HALT if next pc == HALT_ADDR, else FETCH.
- HALT: done=1, imem_req=0, instr_valid=0, pc holds HALT_ADDR (or RESET_PC if entered from start). Counters frozen. start=1 behaves as in IDLE; done drops on the same edge.
- cycle_cnt increments on every edge while state is FETCH or ISSUE. Both counters saturate at all-ones and never wrap.
- done, instr_valid and imem_req are registered-state decodes with no combinational path from inputs. imem_addr = pc register.

Decomposition:
- Package fetch_pkg:
  - typedef enum logic[1:0] fe_state_t {IDLE, FETCH, ISSUE, HALT};
  - localparams for default D/IW/CW.
- One sub-module: sat_counter #(CW) with inc, clr and sync reset, instantiated twice (cycle_cnt, instr_cnt).
- Next-pc mux stays inline in fetch_seq.

Test Plan:
- Reset mid-FETCH, then reset=0 with imem_ack=1 -> state IDLE, imem_req=0, counters 0, done=0; start=1 -> imem_addr=0x000, imem_req=1 next cycle.
- Sequential run, 0-wait ack, no stall, HALT_ADDR=0x004 -> 4 retires at pc 0..3, done=1, instr_cnt=4, cycle_cnt=8.
- 3-cycle ack latency plus stall held 2 cycles on first instruction (imem_data=9'h1A5) -> instr=9'h1A5 stable throughout, retire once, instr_cnt=1, cycle_cnt=3+1+2+1=7 at the retire edge.
- pc=0x010, rel_jump target=0xFFE (-2) -> next imem_addr=0x00E. At pc=0xFFF-1, rel +3 -> wraps to 0x001.
- abs_jump=1 and rel_jump=1 together, target=0x020 -> pc=0x020. abs_jump with target=HALT_ADDR -> done=1, imem_req=0 next cycle.
- CW=4, 20-instruction loop -> instr_cnt and cycle_cnt stick at 0xF. start in HALT -> counters 0, done=0, imem_addr=RESET_PC.
